// File: rtl/aes_iter_core.sv
// +----------------------------------------------------------------------------+
// | Module   : aes_iter_core (with aes_sbox)                                    |
// | Purpose  : Iterative AES encryptor, one round per clock, on-the-fly key     |
// |            schedule, AES-128 (10 rounds) or AES-256 (14 rounds).            |
// | Ports    : clk, rst_n (async active-low)                                    |
// |            in_valid/in_ready, key[KEY_BITS], data_in[128]  - input side     |
// |            out_valid/out_ready, data_out[128]             - output side     |
// |            busy                                           - high in RUN     |
// | Options  : AES_ZEROIZE_EN - clear data_out, state and key register on the   |
// |            output handshake; data_out reads 0 while out_valid is low.       |
// | Revision : 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
`default_nettype none

module aes_sbox (
  input  logic [7:0] a_i,
  output logic [7:0] y_o
);
  // Forward S-box, entry 0 in the MSBs.
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

  logic [10:0] w_idx;
  assign w_idx = 11'd2047 - {a_i, 3'b000};
  assign y_o   = SBOX[w_idx -: 8];
endmodule

module aes_iter_core #(
  parameter int KEY_BITS = 128
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [KEY_BITS-1:0] key,
  input  logic [127:0]        data_in,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [127:0]        data_out,
  output logic                busy
);
  localparam int NR = (KEY_BITS == 256) ? 14 : 10;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DONE = 2'd2} state_e;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  state_e                fsm_q, fsm_d;
  logic [127:0]          state_q;
  logic [KEY_BITS-1:0]   key_q;
  logic [3:0]            round_q;
  logic [7:0]            rcon_q;
  logic [127:0]          dout_q;

  logic [127:0]          w_sb, w_sr, w_mc, w_rk, w_rk_gen, w_round_out;
  logic [KEY_BITS-1:0]   w_key_next;
  logic [31:0]           w_kin, w_ksub, w_t;
  logic                  w_use_rot, w_rcon_adv, w_last;

  // ---------------------------------------------------------------- round path
  for (genvar i = 0; i < 16; i++) begin : g_sub
    aes_sbox u_sbox (.a_i(state_q[127-8*i -: 8]), .y_o(w_sb[127-8*i -: 8]));
  end

  // Byte index is row + 4*col; row r rotates left by r columns.
  for (genvar c = 0; c < 4; c++) begin : g_sr_col
    for (genvar r = 0; r < 4; r++) begin : g_sr_row
      assign w_sr[127-8*(4*c+r) -: 8] = w_sb[127-8*(4*((c+r)%4)+r) -: 8];
    end
  end

  for (genvar c = 0; c < 4; c++) begin : g_mix
    logic [7:0] a0, a1, a2, a3;
    assign a0 = w_sr[127-32*c -: 8];
    assign a1 = w_sr[119-32*c -: 8];
    assign a2 = w_sr[111-32*c -: 8];
    assign a3 = w_sr[103-32*c -: 8];
    assign w_mc[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
    assign w_mc[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
    assign w_mc[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
    assign w_mc[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
  end

  assign w_last      = (round_q == 4'(NR));
  assign w_round_out = (w_last ? w_sr : w_mc) ^ w_rk;

  // -------------------------------------------------------------- key schedule
  // The newest four key words always sit in key_q[127:0]; the generated round
  // key is the oldest 128 bits of key_q folded with the transformed last word.
  assign w_kin = w_use_rot ? {key_q[23:0], key_q[31:24]} : key_q[31:0];

  for (genvar i = 0; i < 4; i++) begin : g_ksub
    aes_sbox u_sbox (.a_i(w_kin[31-8*i -: 8]), .y_o(w_ksub[31-8*i -: 8]));
  end

  assign w_t = w_ksub ^ (w_use_rot ? {rcon_q, 24'h000000} : 32'h0);
  assign w_rk_gen[127:96] = key_q[KEY_BITS-1   -: 32] ^ w_t;
  assign w_rk_gen[95:64]  = key_q[KEY_BITS-33  -: 32] ^ w_rk_gen[127:96];
  assign w_rk_gen[63:32]  = key_q[KEY_BITS-65  -: 32] ^ w_rk_gen[95:64];
  assign w_rk_gen[31:0]   = key_q[KEY_BITS-97  -: 32] ^ w_rk_gen[63:32];

  if (KEY_BITS == 128) begin : g_k128
    assign w_use_rot  = 1'b1;
    assign w_rcon_adv = 1'b1;
    assign w_rk       = w_rk_gen;
    assign w_key_next = w_rk_gen;
  end else if (KEY_BITS == 256) begin : g_k256
    logic w_first;
    // Round 1 uses the second half of the cipher key as-is; afterwards even
    // rounds use RotWord+Rcon and odd rounds SubWord only.
    assign w_first    = (round_q == 4'd1);
    assign w_use_rot  = ~round_q[0];
    assign w_rcon_adv = ~round_q[0];
    assign w_rk       = w_first ? key_q[127:0] : w_rk_gen;
    assign w_key_next = w_first ? key_q : {key_q[127:0], w_rk_gen};
  end else begin : g_bad_key
    $error("aes_iter_core: KEY_BITS must be 128 or 256");
  end

  // ---------------------------------------------------------------------- FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) fsm_q <= S_IDLE;
    else        fsm_q <= fsm_d;
  end

  always_comb begin
    fsm_d = fsm_q;
    unique case (fsm_q)
      S_IDLE:  if (in_valid)  fsm_d = S_RUN;
      S_RUN:   if (w_last)    fsm_d = S_DONE;
      S_DONE:  if (out_ready) fsm_d = S_IDLE;
      default:                fsm_d = S_IDLE;
    endcase
  end

  assign in_ready  = (fsm_q == S_IDLE);
  assign busy      = (fsm_q == S_RUN);
  assign out_valid = (fsm_q == S_DONE);

  // ----------------------------------------------------------------- datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= '0;
      key_q   <= '0;
      round_q <= '0;
      rcon_q  <= '0;
      dout_q  <= '0;
    end else begin
      unique case (fsm_q)
        S_IDLE: if (in_valid) begin
          state_q <= data_in ^ key[KEY_BITS-1 -: 128];
          key_q   <= key;
          round_q <= 4'd1;
          rcon_q  <= 8'h01;
        end
        S_RUN: begin
          state_q <= w_round_out;
          key_q   <= w_key_next;
          round_q <= round_q + 4'd1;
          if (w_rcon_adv) rcon_q <= xtime(rcon_q);
          if (w_last)     dout_q <= w_round_out;
        end
        S_DONE: begin
`ifdef AES_ZEROIZE_EN
          if (out_ready) begin
            dout_q  <= '0;
            state_q <= '0;
            key_q   <= '0;
          end
`endif
        end
        default: ;
      endcase
    end
  end

`ifdef AES_ZEROIZE_EN
  assign data_out = out_valid ? dout_q : 128'h0;
`else
  assign data_out = dout_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_aes_iter_core.sv
// +----------------------------------------------------------------------------+
// | Module   : tb_aes_iter_core                                                 |
// | Purpose  : Scoreboard bench for aes_iter_core, one AES-128 and one AES-256  |
// |            instance driven with FIPS-197 vectors.                           |
// | Revision : 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_aes_iter_core;
  localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] P1 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] K2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] P2 = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] C2 = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [255:0] K3 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] C3 = 128'h8ea2b7ca516745bfeafc49904b496089;
`ifdef AES_ZEROIZE_EN
  localparam logic [127:0] C1_AFTER_HS = 128'h0;
`else
  localparam logic [127:0] C1_AFTER_HS = C1;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic         a_in_valid = 1'b0, a_in_ready, a_out_valid, a_out_ready = 1'b1, a_busy;
  logic [127:0] a_key = '0, a_din = '0, a_dout;
  logic         b_in_valid = 1'b0, b_in_ready, b_out_valid, b_out_ready = 1'b1, b_busy;
  logic [255:0] b_key = '0;
  logic [127:0] b_din = '0, b_dout;

  aes_iter_core #(.KEY_BITS(128)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .key(a_key), .data_in(a_din), .out_valid(a_out_valid), .out_ready(a_out_ready),
    .data_out(a_dout), .busy(a_busy));

  aes_iter_core #(.KEY_BITS(256)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .key(b_key), .data_in(b_din), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .data_out(b_dout), .busy(b_busy));

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_pass = 0;

  typedef struct {
    logic [127:0] ct;
    int           acc;
  } exp_t;
  exp_t q_a[$];
  exp_t q_b[$];

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  // ------------------------------------------------------------- monitors
  logic         a_vprev = 1'b0, b_vprev = 1'b0;
  logic [127:0] a_hold = '0, b_hold = '0;

  always @(negedge clk) begin
    exp_t e;
    if (a_out_valid && !a_vprev) begin
      if (q_a.size() == 0) begin
        n_chk++;
        $display("FAIL a_unexpected_output: got %h with no block outstanding", a_dout);
      end else begin
        e = q_a.pop_front();
        check("a_ciphertext", a_dout, e.ct);
        check("a_latency", 128'(cyc - e.acc), 128'd10);
      end
      a_hold = a_dout;
    end else if (a_out_valid && a_out_ready) begin
      check("a_hold_at_handshake", a_dout, a_hold);
    end
    a_vprev = a_out_valid;
  end

  always @(negedge clk) begin
    exp_t e;
    if (b_out_valid && !b_vprev) begin
      if (q_b.size() == 0) begin
        n_chk++;
        $display("FAIL b_unexpected_output: got %h with no block outstanding", b_dout);
      end else begin
        e = q_b.pop_front();
        check("b_ciphertext", b_dout, e.ct);
        check("b_latency", 128'(cyc - e.acc), 128'd14);
      end
      b_hold = b_dout;
    end else if (b_out_valid && b_out_ready) begin
      check("b_hold_at_handshake", b_dout, b_hold);
    end
    b_vprev = b_out_valid;
  end

  // --------------------------------------------------------------- drivers
  task automatic drive(input int d, input logic v, input logic [255:0] k, input logic [127:0] p);
    if (d != 0) begin
      b_in_valid = v; b_key = k; b_din = p;
    end else begin
      a_in_valid = v; a_key = k[127:0]; a_din = p;
    end
  endtask

  // Called just after a falling edge; returns just after a falling edge.
  task automatic send(input int d, input logic [255:0] k, input logic [127:0] p,
                      input logic [127:0] c, input bit keep_busy, output int acc);
    int   t;
    exp_t e;
    t   = 0;
    acc = -1;
    while (!(d != 0 ? b_in_ready : a_in_ready)) begin
      if (t == 100) begin
        n_chk++;
        $display("FAIL send_timeout dut%0d: in_ready low, required high", d);
        return;
      end
      @(negedge clk);
      t++;
    end
    drive(d, 1'b1, k, p);
    @(posedge clk);
    #1;
    acc   = cyc;
    e.ct  = c;
    e.acc = acc;
    if (d != 0) q_b.push_back(e);
    else        q_a.push_back(e);
    @(negedge clk);
    if (keep_busy) begin
      t = 0;
      while (!(d != 0 ? b_in_ready : a_in_ready) && t < 100) begin
        drive(d, 1'b1, {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom},
              {$urandom, $urandom, $urandom, $urandom});
        @(negedge clk);
        t++;
      end
    end
    drive(d, 1'b0, '0, '0);
  endtask

  task automatic wait_idle(input int d);
    int t;
    t = 0;
    while (!((d != 0 ? b_in_ready : a_in_ready) && !(d != 0 ? b_out_valid : a_out_valid))) begin
      if (t == 100) begin
        n_chk++;
        $display("FAIL idle_timeout dut%0d: core not idle, required idle", d);
        return;
      end
      @(negedge clk);
      t++;
    end
  endtask

  // ------------------------------------------------------------- sequence
  initial begin
    int acc0, acc1, t;
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_a_in_ready", a_in_ready, 1);
    check("rst_a_out_valid", a_out_valid, 0);
    check("rst_a_busy", a_busy, 0);
    check("rst_a_data_out", a_dout, 0);
    check("rst_b_in_ready", b_in_ready, 1);
    check("rst_b_data_out", b_dout, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic AES-128 vector, out_ready high throughout.
    send(0, 256'(K1), P1, C1, 1'b0, acc0);
    check("a_busy_in_run", a_busy, 1);
    check("a_in_ready_in_run", a_in_ready, 0);
    wait_idle(0);
    check("a_data_out_after_hs", a_dout, C1_AFTER_HS);
    check("a_busy_after_hs", a_busy, 0);

    // Consumer stalls for five cycles.
    a_out_ready = 1'b0;
    send(0, 256'(K2), P2, C2, 1'b0, acc0);
    t = 0;
    while (!a_out_valid && t < 40) begin
      @(negedge clk);
      t++;
    end
    for (int i = 0; i < 5; i++) begin
      check("stall_out_valid", a_out_valid, 1);
      check("stall_in_ready", a_in_ready, 0);
      check("stall_data_out", a_dout, C2);
      @(negedge clk);
    end
    a_out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("post_hs_in_ready", a_in_ready, 1);
    check("post_hs_out_valid", a_out_valid, 0);
    @(negedge clk);

    // Inputs churn during RUN; next block back-to-back.
    send(0, 256'(K1), P1, C1, 1'b1, acc0);
    send(0, 256'(K2), P2, C2, 1'b0, acc1);
    check("a_block_period", 128'(acc1 - acc0), 128'd12);
    wait_idle(0);

    // AES-256 vector.
    send(1, K3, P1, C3, 1'b0, acc0);
    wait_idle(1);

    // Reset during round 5 discards the block.
    send(0, 256'(K2), P2, C2, 1'b0, acc0);
    repeat (4) @(negedge clk);
    check("a_busy_before_rst", a_busy, 1);
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", a_out_valid, 0);
    check("midrst_data_out", a_dout, 0);
    check("midrst_in_ready", a_in_ready, 1);
    check("midrst_busy", a_busy, 0);
    if (q_a.size() != 0) void'(q_a.pop_back());
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send(0, 256'(K1), P1, C1, 1'b0, acc0);
    wait_idle(0);

    repeat (2) @(negedge clk);
    check("a_queue_drained", 128'(q_a.size()), 0);
    check("b_queue_drained", 128'(q_b.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

`default_nettype wire

// File: doc/aes_iter_core.md
Name: aes_iter_core

Overview:
- Iterative AES encryption engine; one round per clock, with the key schedule computed on the fly.
- Key size is selected by a parameter: AES-128 (10 rounds) or AES-256 (14 rounds).
- Valid/ready handshake on input and output; one block in flight at a time.
- Area-lean sibling of the fully unrolled AES-128 pipeline, for links that need 128/256 support rather than one block per cycle.

Parameters:
KEY_BITS, 128, key length; legal values 128 or 256. Any other value is an elaboration error. Nr = 10 for 128, 14 for 256.

Ports:
clk  in  1  clock, all logic on rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  plaintext and key present
in_ready  out  1  core can accept a block
key  in  KEY_BITS  cipher key; FIPS-197 byte order, first byte in MSBs
data_in  in  128  plaintext; byte 0 in [127:120], column-major state
out_valid  out  1  ciphertext available
out_ready  in  1  consumer accepts ciphertext
data_out  out  128  ciphertext, same byte order as data_in
busy  out  1  high in RUN state

Behaviour:
- Reset (async assert, sync release):
  - FSM goes to IDLE.
  - in_ready=1, out_valid=0, busy=0, data_out=0.
  - Round counter, state register and key register are all cleared.
- FSM states:
  - IDLE: in_ready=1. On in_valid & in_ready:
    - state <= data_in ^ key[KEY_BITS-1 -: 128].
    - Key register <= key; round <= 1; go to RUN.
  - RUN: in_ready=0, busy=1. Each edge applies round r: SubBytes, ShiftRows, MixColumns, AddRoundKey(rk_r).
    - When r == Nr, MixColumns is skipped; result is loaded into data_out, out_valid <= 1, go to DONE.
  - DONE: out_valid=1, data_out stable. On out_ready go to IDLE, out_valid <= 0.
- Latency: out_valid rises on the Nr-th rising edge after the accepting edge (10 or 14).
  - Minimum block period is Nr+2 cycles, since in_ready is high only in IDLE.
- Key schedule:
  - KEY_BITS=128: rk_r is derived from rk_{r-1} in the cycle it is used, with Rcon advanced per round.
  - KEY_BITS=256: a 256-bit register holds two consecutive round keys.
    - rk_1 is the low half of the key.
    - From r≥2, the next 128-bit half is generated each round, alternating between RotWord+SubWord+Rcon (even words) and SubWord only.
  - Rcon sequence is 01,02,04,08,10,20,40,80,1b,36, advanced only when used.
- key and data_in are sampled only on the accepting edge; later changes are ignored until the next accept.
- in_valid while not in IDLE: ignored; no acceptance occurs.
- out_ready while out_valid=0: no effect.
- out_valid, once high, stays high with data_out stable until out_ready is sampled high.
- rst_n asserted mid-RUN or in DONE: block is discarded, reset values apply immediately, no out_valid pulse.
- S-box: combinational aes_sbox submodule; 16 instances for state, 4 for key schedule.

Optional Feature:
- Macro AES_ZEROIZE_EN.
- Defined:
  - On the output handshake edge, data_out, the state register and the key register are cleared to 0.
  - data_out reads 0 whenever out_valid=0.
- Undefined: data_out holds the last ciphertext until the next completion; internal registers retain their contents.

Test Plan:
- KEY_BITS=128, key 000102030405060708090a0b0c0d0e0f, data 00112233445566778899aabbccddeeff, out_ready=1 → data_out 69c4e0d86a7b0430d8cdb78070b4c55a, out_valid exactly 10 edges after accept.
- KEY_BITS=128, key 2b7e151628aed2a6abf7158809cf4f3c, data 3243f6a8885a308d313198a2e0370734, out_ready held 0 for 5 cycles → out_valid and data_out 3925841d02dc09fbdc118597196a0b32 held stable; in_ready=0 until one cycle after the handshake.
- KEY_BITS=256, key 000102…1e1f, data 00112233445566778899aabbccddeeff → 8ea2b7ca516745bfeafc49904b496089 after 14 edges.
- in_valid held high with key/data changed every cycle during RUN → only the first block is processed; output equals that block's vector; back-to-back blocks have a period of Nr+2 cycles.
- rst_n pulsed low at round 5 → out_valid=0 and data_out=0 immediately; a new block after release gives the correct ciphertext.
- Macro on vs off, after a handshake with out_ready=1 → data_out reads 0 (on) or holds 69c4e0d8… (off).
